// File: rtl/dp_pkg.sv
`default_nettype none
// =============================================================================
// Module   : dp_pkg
// Brief    : Shared width constant and ALU opcode encodings for cpu_datapath.
// Revision : 1.0 - initial release
// =============================================================================
package dp_pkg;

    localparam int WIDTH = 32;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

endpackage
`default_nettype wire

// File: rtl/dp_alu.sv
`default_nettype none
// =============================================================================
// Module   : dp_alu
// Brief    : Combinational ALU, A = Y, B = bus, 2*WIDTH-bit result.
// Revision : 1.0 - initial release
// =============================================================================
module dp_alu
    import dp_pkg::*;
#(
    parameter int WIDTH = dp_pkg::WIDTH
) (
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic [4:0]         opcode_i,
    output logic [2*WIDTH-1:0] result_o
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0]     w_sh;
    logic [SHW:0]       w_sh_inv;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_uquo;
    logic [WIDTH-1:0]   w_urem;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_sh     = b_i[SHW-1:0];
    assign w_sh_inv = (SHW+1)'(WIDTH) - {1'b0, w_sh};

    assign w_prod = {{WIDTH{a_i[WIDTH-1]}}, a_i} * {{WIDTH{b_i[WIDTH-1]}}, b_i};

    // Signed divide through magnitudes so the most-negative dividend never traps.
    assign w_a_neg = a_i[WIDTH-1];
    assign w_b_neg = b_i[WIDTH-1];
    assign w_a_mag = w_a_neg ? -a_i : a_i;
    assign w_b_mag = w_b_neg ? -b_i : b_i;
    assign w_uquo  = (w_b_mag == '0) ? '0 : w_a_mag / w_b_mag;
    assign w_urem  = (w_b_mag == '0) ? '0 : w_a_mag % w_b_mag;
    assign w_quo   = (w_a_neg ^ w_b_neg) ? -w_uquo : w_uquo;
    assign w_rem   = w_a_neg ? -w_urem : w_urem;

    always_comb begin
        result_o = '0;
        case (opcode_i)
            OP_ADD:  result_o[WIDTH-1:0] = a_i + b_i;
            OP_SUB:  result_o[WIDTH-1:0] = a_i - b_i;
            OP_AND:  result_o[WIDTH-1:0] = a_i & b_i;
            OP_OR:   result_o[WIDTH-1:0] = a_i | b_i;
            OP_ROR:  result_o[WIDTH-1:0] = (a_i >> w_sh) | (a_i << w_sh_inv);
            OP_ROL:  result_o[WIDTH-1:0] = (a_i << w_sh) | (a_i >> w_sh_inv);
            OP_SHR:  result_o[WIDTH-1:0] = a_i >> w_sh;
            OP_SHRA: result_o[WIDTH-1:0] = $signed(a_i) >>> w_sh;
            OP_SHL:  result_o[WIDTH-1:0] = a_i << w_sh;
            OP_MUL:  result_o            = w_prod;
            OP_DIV:  result_o            = (b_i == '0) ? '0 : {w_rem, w_quo};
            OP_NEG:  result_o[WIDTH-1:0] = -b_i;
            OP_NOT:  result_o[WIDTH-1:0] = ~b_i;
            default: result_o            = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cpu_datapath.sv
`default_nettype none
// =============================================================================
// Module   : cpu_datapath
// Brief    : Single-bus 32-bit CPU datapath (R0-R15, HI/LO, PC, IR, MAR, MDR,
//            Y, Z/ZHI/ZLO) with priority-encoded bus and combinational ALU.
//            Define DP_INPORT_EN to add the InPort_data input port.
// Revision : 1.0 - initial release
// =============================================================================
module cpu_datapath
    import dp_pkg::*;
#(
    parameter int WIDTH = dp_pkg::WIDTH
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               R0in,  R1in,  R2in,  R3in,
    input  logic               R4in,  R5in,  R6in,  R7in,
    input  logic               R8in,  R9in,  R10in, R11in,
    input  logic               R12in, R13in, R14in, R15in,
    input  logic               R0out,  R1out,  R2out,  R3out,
    input  logic               R4out,  R5out,  R6out,  R7out,
    input  logic               R8out,  R9out,  R10out, R11out,
    input  logic               R12out, R13out, R14out, R15out,
    input  logic               HIin,
    input  logic               Loin,
    input  logic               PCin,
    input  logic               MDRin,
    input  logic               MARin,
    input  logic               IRin,
    input  logic               Yin,
    input  logic               Zin,
    input  logic               ZHIin,
    input  logic               ZLOin,
    input  logic               HIout,
    input  logic               Loout,
    input  logic               PCout,
    input  logic               MDRout,
    input  logic               Yout,
    input  logic               ZHIout,
    input  logic               ZLOout,
    input  logic               InPortout,
    input  logic               Cout,
    input  logic               ZHighSelect,
    input  logic               ZLowSelect,
    input  logic               MDRread,
    input  logic               IncPC,
    input  logic [4:0]         ALU_opcode,
    input  logic [WIDTH-1:0]   Mdatain,
`ifdef DP_INPORT_EN
    input  logic [WIDTH-1:0]   InPort_data,
`endif
    output logic [WIDTH-1:0]   R0,  R1,  R2,  R3,
    output logic [WIDTH-1:0]   R4,  R5,  R6,  R7,
    output logic [WIDTH-1:0]   R8,  R9,  R10, R11,
    output logic [WIDTH-1:0]   R12, R13, R14, R15,
    output logic [WIDTH-1:0]   HI,
    output logic [WIDTH-1:0]   LO,
    output logic [WIDTH-1:0]   Y,
    output logic [WIDTH-1:0]   ZLO,
    output logic [WIDTH-1:0]   ZHI,
    output logic [WIDTH-1:0]   IR,
    output logic [WIDTH-1:0]   MAR,
    output logic [2*WIDTH-1:0] Z_register
);

    logic [15:0]        w_rin;
    logic [15:0]        w_rout;
    logic [WIDTH-1:0]   w_gpr [16];
    logic [WIDTH-1:0]   w_bus;
    logic [WIDTH-1:0]   w_c;
    logic [WIDTH-1:0]   w_inport;
    logic [2*WIDTH-1:0] w_alu_res;

    logic [WIDTH-1:0]   hi_q, lo_q, pc_q, ir_q, mar_q, mdr_q, y_q, zhi_q, zlo_q;
    logic [2*WIDTH-1:0] z_q;
    logic [WIDTH-1:0]   pc_d, mdr_d;

    assign w_rin  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                     R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};
    assign w_rout = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                     R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_gpr
            logic [WIDTH-1:0] r_q;
            always_ff @(posedge clk or posedge clr) begin
                if (clr)
                    r_q <= '0;
                else if (w_rin[gi])
                    r_q <= w_bus;
            end
            assign w_gpr[gi] = r_q;
        end
    endgenerate

    assign w_c = {{(WIDTH-19){ir_q[18]}}, ir_q[18:0]};

`ifdef DP_INPORT_EN
    assign w_inport = InPort_data;
`else
    assign w_inport = '0;
`endif

    // Lowest priority first; each later match overrides the earlier ones.
    always_comb begin
        w_bus = '0;
        if (ZLowSelect)  w_bus = z_q[WIDTH-1:0];
        if (ZHighSelect) w_bus = z_q[2*WIDTH-1:WIDTH];
        if (Cout)        w_bus = w_c;
        if (InPortout)   w_bus = w_inport;
        if (MDRout)      w_bus = mdr_q;
        if (PCout)       w_bus = pc_q;
        if (Yout)        w_bus = y_q;
        if (ZLOout)      w_bus = zlo_q;
        if (ZHIout)      w_bus = zhi_q;
        if (Loout)       w_bus = lo_q;
        if (HIout)       w_bus = hi_q;
        for (int i = 15; i >= 0; i--) begin
            if (w_rout[i]) w_bus = w_gpr[i];
        end
    end

    dp_alu #(
        .WIDTH    (WIDTH)
    ) u_alu (
        .a_i      (y_q),
        .b_i      (w_bus),
        .opcode_i (ALU_opcode),
        .result_o (w_alu_res)
    );

    always_comb begin
        pc_d = pc_q;
        if (PCin)
            pc_d = w_bus;
        else if (IncPC)
            pc_d = pc_q + WIDTH'(1);
    end

    assign mdr_d = MDRread ? Mdatain : w_bus;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            hi_q  <= '0;
            lo_q  <= '0;
            pc_q  <= '0;
            ir_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            y_q   <= '0;
            z_q   <= '0;
            zhi_q <= '0;
            zlo_q <= '0;
        end else begin
            pc_q <= pc_d;
            if (HIin)  hi_q  <= w_bus;
            if (Loin)  lo_q  <= w_bus;
            if (IRin)  ir_q  <= w_bus;
            if (MARin) mar_q <= w_bus;
            if (MDRin) mdr_q <= mdr_d;
            if (Yin)   y_q   <= w_bus;
            if (Zin)   z_q   <= w_alu_res;
            if (ZHIin) zhi_q <= w_alu_res[2*WIDTH-1:WIDTH];
            if (ZLOin) zlo_q <= w_alu_res[WIDTH-1:0];
        end
    end

    assign R0  = w_gpr[0];
    assign R1  = w_gpr[1];
    assign R2  = w_gpr[2];
    assign R3  = w_gpr[3];
    assign R4  = w_gpr[4];
    assign R5  = w_gpr[5];
    assign R6  = w_gpr[6];
    assign R7  = w_gpr[7];
    assign R8  = w_gpr[8];
    assign R9  = w_gpr[9];
    assign R10 = w_gpr[10];
    assign R11 = w_gpr[11];
    assign R12 = w_gpr[12];
    assign R13 = w_gpr[13];
    assign R14 = w_gpr[14];
    assign R15 = w_gpr[15];

    assign HI         = hi_q;
    assign LO         = lo_q;
    assign Y          = y_q;
    assign ZLO        = zlo_q;
    assign ZHI        = zhi_q;
    assign IR         = ir_q;
    assign MAR        = mar_q;
    assign Z_register = z_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_datapath.sv
`default_nettype none
// =============================================================================
// Module   : tb_cpu_datapath
// Brief    : Directed scoreboard bench for cpu_datapath (default build, or with
//            DP_INPORT_EN defined).
// Revision : 1.0 - initial release
// =============================================================================
module tb_cpu_datapath;

    logic        clk = 1'b0;
    logic        clr;
    logic [15:0] Rin, Rout;
    logic        HIin, Loin, PCin, MDRin, MARin, IRin, Yin, Zin, ZHIin, ZLOin;
    logic        HIout, Loout, PCout, MDRout, Yout, ZHIout, ZLOout, InPortout, Cout;
    logic        ZHighSelect, ZLowSelect, MDRread, IncPC;
    logic [4:0]  ALU_opcode;
    logic [31:0] Mdatain;
`ifdef DP_INPORT_EN
    logic [31:0] InPort_data = 32'hC0DE_0123;
`endif
    logic [31:0] Rv [16];
    logic [31:0] HI, LO, Y, ZLO, ZHI, IR, MAR;
    logic [63:0] Z_register;

    typedef struct {
        string       tag;
        logic [63:0] exp;
    } sb_t;
    sb_t sb[$];
    int  n_cmp  = 0;
    int  n_fail = 0;

    cpu_datapath dut (
        .clk(clk), .clr(clr),
        .R0in(Rin[0]),   .R1in(Rin[1]),   .R2in(Rin[2]),   .R3in(Rin[3]),
        .R4in(Rin[4]),   .R5in(Rin[5]),   .R6in(Rin[6]),   .R7in(Rin[7]),
        .R8in(Rin[8]),   .R9in(Rin[9]),   .R10in(Rin[10]), .R11in(Rin[11]),
        .R12in(Rin[12]), .R13in(Rin[13]), .R14in(Rin[14]), .R15in(Rin[15]),
        .R0out(Rout[0]),   .R1out(Rout[1]),   .R2out(Rout[2]),   .R3out(Rout[3]),
        .R4out(Rout[4]),   .R5out(Rout[5]),   .R6out(Rout[6]),   .R7out(Rout[7]),
        .R8out(Rout[8]),   .R9out(Rout[9]),   .R10out(Rout[10]), .R11out(Rout[11]),
        .R12out(Rout[12]), .R13out(Rout[13]), .R14out(Rout[14]), .R15out(Rout[15]),
        .HIin(HIin), .Loin(Loin), .PCin(PCin), .MDRin(MDRin), .MARin(MARin),
        .IRin(IRin), .Yin(Yin), .Zin(Zin), .ZHIin(ZHIin), .ZLOin(ZLOin),
        .HIout(HIout), .Loout(Loout), .PCout(PCout), .MDRout(MDRout), .Yout(Yout),
        .ZHIout(ZHIout), .ZLOout(ZLOout), .InPortout(InPortout), .Cout(Cout),
        .ZHighSelect(ZHighSelect), .ZLowSelect(ZLowSelect),
        .MDRread(MDRread), .IncPC(IncPC), .ALU_opcode(ALU_opcode), .Mdatain(Mdatain),
`ifdef DP_INPORT_EN
        .InPort_data(InPort_data),
`endif
        .R0(Rv[0]),   .R1(Rv[1]),   .R2(Rv[2]),   .R3(Rv[3]),
        .R4(Rv[4]),   .R5(Rv[5]),   .R6(Rv[6]),   .R7(Rv[7]),
        .R8(Rv[8]),   .R9(Rv[9]),   .R10(Rv[10]), .R11(Rv[11]),
        .R12(Rv[12]), .R13(Rv[13]), .R14(Rv[14]), .R15(Rv[15]),
        .HI(HI), .LO(LO), .Y(Y), .ZLO(ZLO), .ZHI(ZHI), .IR(IR), .MAR(MAR),
        .Z_register(Z_register)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $error("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    task automatic idle();
        Rin = '0; Rout = '0;
        HIin = 0; Loin = 0; PCin = 0; MDRin = 0; MARin = 0; IRin = 0; Yin = 0;
        Zin = 0; ZHIin = 0; ZLOin = 0;
        HIout = 0; Loout = 0; PCout = 0; MDRout = 0; Yout = 0; ZHIout = 0;
        ZLOout = 0; InPortout = 0; Cout = 0; ZHighSelect = 0; ZLowSelect = 0;
        MDRread = 0; IncPC = 0; ALU_opcode = '0; Mdatain = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic push(input string tag, input logic [63:0] exp);
        sb.push_back('{tag, exp});
    endtask

    task automatic pop_check(input logic [63:0] obs);
        sb_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL sb_underflow: observed %h expected queued entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic load_r(input int idx, input logic [31:0] v);
        Mdatain = v; MDRread = 1; MDRin = 1;
        tick();
        MDRout = 1; Rin[idx] = 1;
        tick();
    endtask

    task automatic to_y(input int idx);
        Rout[idx] = 1; Yin = 1;
        tick();
    endtask

    task automatic alu(input int idx, input logic [4:0] op);
        Rout[idx] = 1; ALU_opcode = op; Zin = 1; ZHIin = 1; ZLOin = 1;
        tick();
    endtask

    initial begin
        idle();
        clr = 1;
        @(negedge clk);
        @(negedge clk);
        push("rst_R0", 64'h0);  pop_check({32'h0, Rv[0]});
        push("rst_Z", 64'h0);   pop_check(Z_register);
        push("rst_IR", 64'h0);  pop_check({32'h0, IR});
        clr = 0;
        tick();

        // load path
        push("load_R0", 64'hF); load_r(0, 32'h0000000F); pop_check({32'h0, Rv[0]});
        push("load_R1", 64'h4); load_r(1, 32'h00000004); pop_check({32'h0, Rv[1]});

        // NOT with Yout and ZLowSelect in the same cycle
        push("Y_from_R1", 64'h4); to_y(1); pop_check({32'h0, Y});
        push("NOT_ZLO", 64'hFFFFFFFB);
        push("NOT_Z", 64'h00000000FFFFFFFB);
        Yout = 1; ALU_opcode = 5'b10010; Zin = 1; ZLOin = 1; ZLowSelect = 1;
        tick();
        pop_check({32'h0, ZLO}); pop_check(Z_register);
        push("ZLOout_R0", 64'hFFFFFFFB);
        ZLOout = 1; R0_in_set: Rin[0] = 1; ZLowSelect = 1;
        tick();
        pop_check({32'h0, Rv[0]});

        // ADD / SUB
        load_r(2, 32'd7); load_r(3, 32'd5);
        to_y(2);
        push("ADD", 64'd12);        alu(3, 5'b00011); pop_check({32'h0, ZLO});
        push("SUB", 64'd2);         alu(3, 5'b00100); pop_check({32'h0, ZLO});
        push("AND", 64'd5);         alu(3, 5'b00101); pop_check({32'h0, ZLO});
        push("OR", 64'd7);          alu(3, 5'b00110); pop_check({32'h0, ZLO});
        push("NEG", 64'hFFFFFFFB);  alu(3, 5'b10001); pop_check(Z_register);
        push("BAD_OP", 64'h0);      alu(3, 5'b11111); pop_check(Z_register);
        push("Y_hold", 64'd7);
        Yin = 1; Yout = 1;
        tick();
        pop_check({32'h0, Y});
        load_r(5, 32'd1);
        to_y(4);
        push("SUB_wrap", 64'hFFFFFFFF); alu(5, 5'b00100); pop_check({32'h0, ZLO});

        // MUL / DIV
        load_r(6, 32'hFFFFFFFA);
        to_y(6);
        push("MUL_Z", 64'hFFFFFFFFFFFFFFE8);
        push("MUL_ZHI", 64'hFFFFFFFF);
        alu(1, 5'b01111);
        pop_check(Z_register); pop_check({32'h0, ZHI});
        load_r(7, 32'd17);
        to_y(7);
        push("DIV_ZLO", 64'd3); push("DIV_ZHI", 64'd2); push("DIV_Z", 64'h0000000200000003);
        alu(3, 5'b10000);
        pop_check({32'h0, ZLO}); pop_check({32'h0, ZHI}); pop_check(Z_register);
        push("ZHIout", 64'd2);
        ZHIout = 1; Rin[12] = 1;
        tick();
        pop_check({32'h0, Rv[12]});
        push("DIV_by0", 64'h0);     alu(4, 5'b10000); pop_check(Z_register);
        load_r(8, 32'hFFFFFFEF);
        to_y(8);
        push("DIV_neg", 64'hFFFFFFFEFFFFFFFD); alu(3, 5'b10000); pop_check(Z_register);

        // shifts and rotates of 0x80000001 by 4
        load_r(9, 32'h80000001);
        to_y(9);
        push("ROR", 64'h18000000);  alu(1, 5'b00111); pop_check(Z_register);
        push("ROL", 64'h00000018);  alu(1, 5'b01000); pop_check(Z_register);
        push("SHR", 64'h08000000);  alu(1, 5'b01001); pop_check(Z_register);
        push("SHRA", 64'hF8000000); alu(1, 5'b01010); pop_check(Z_register);
        push("SHL", 64'h00000010);  alu(1, 5'b01011); pop_check(Z_register);

        // PC increment, PCin priority, wrap
        IncPC = 1; tick(); IncPC = 1; tick(); IncPC = 1; tick();
        push("PC_inc3", 64'd3);
        PCout = 1; Rin[10] = 1;
        tick();
        pop_check({32'h0, Rv[10]});
        push("PCin_over_Inc", 64'd5);
        Rout[3] = 1; PCin = 1; IncPC = 1;
        tick();
        PCout = 1; Rin[11] = 1;
        tick();
        pop_check({32'h0, Rv[11]});
        load_r(13, 32'hFFFFFFFF);
        Rout[13] = 1; PCin = 1; tick();
        IncPC = 1; tick();
        push("PC_wrap", 64'h0);
        PCout = 1; Rin[14] = 1;
        tick();
        pop_check({32'h0, Rv[14]});

        // bus priority and idle bus
        push("prio_R2_Y", 64'd7);
        Rout[2] = 1; Yout = 1; Rin[12] = 1;
        tick();
        pop_check({32'h0, Rv[12]});
        push("prio_R2_R3", 64'd7);
        Rout[2] = 1; Rout[3] = 1; Rin[9] = 1;
        tick();
        pop_check({32'h0, Rv[9]});
        push("bus_idle", 64'h0);
        Rin[13] = 1;
        tick();
        pop_check({32'h0, Rv[13]});

        // IR, C sign-extension, HI/LO, MAR, InPort
        push("IR", 64'hABC40001);
        push("C_sext", 64'hFFFC0001);
        Mdatain = 32'hABC40001; MDRread = 1; MDRin = 1; tick();
        MDRout = 1; IRin = 1; tick();
        pop_check({32'h0, IR});
        Cout = 1; Rin[14] = 1; tick();
        pop_check({32'h0, Rv[14]});
        push("HI", 64'hABC40001); push("LO", 64'hABC40001); push("MAR", 64'hABC40001);
        MDRout = 1; HIin = 1; MARin = 1; tick();
        HIout = 1; Loin = 1; tick();
        pop_check({32'h0, HI}); pop_check({32'h0, LO}); pop_check({32'h0, MAR});
        load_r(15, 32'h55);
`ifdef DP_INPORT_EN
        push("InPort", 64'hC0DE0123);
`else
        push("InPort", 64'h0);
`endif
        InPortout = 1; Rin[15] = 1; tick();
        pop_check({32'h0, Rv[15]});

        // asynchronous clear mid-run
        clr = 1;
        #1;
        push("aclr_R2", 64'h0); push("aclr_Z", 64'h0); push("aclr_Y", 64'h0);
        push("aclr_HI", 64'h0); push("aclr_IR", 64'h0);
        pop_check({32'h0, Rv[2]}); pop_check(Z_register); pop_check({32'h0, Y});
        pop_check({32'h0, HI}); pop_check({32'h0, IR});
        clr = 0;

        n_cmp++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_drain: observed %0d expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
32-bit bus-based CPU datapath: sixteen general registers R0-R15, HI, LO, PC, IR, MAR, MDR, Y, a 64-bit Z result register with ZHI/ZLO halves, and a combinational ALU.
- A single 32-bit internal bus is driven by a priority encoder from one-hot *out strobes.
- Every storage element loads from the bus, or from the ALU, on the rising clock edge when its *in strobe is high.
- The block is controlled step by step by an external control unit, or by a bench acting as one.

Parameters:
WIDTH, 32, bus/register width (64-bit Z is 2*WIDTH)

Ports:
clk  input  1  rising-edge clock
clr  input  1  asynchronous active-high reset of all registers
R0in..R15in  input  1 each  load Rn from bus
R0out..R15out  input  1 each  drive Rn onto bus
HIin, Loin, PCin, MDRin, MARin, IRin, Yin  input  1 each  register load strobes
Zin, ZHIin, ZLOin  input  1 each  load Z / ZHI / ZLO from ALU result
HIout, Loout, PCout, MDRout, Yout, ZHIout, ZLOout, InPortout, Cout  input  1 each  bus drive strobes
ZHighSelect, ZLowSelect  input  1 each  drive Z[63:32] / Z[31:0] onto bus
MDRread  input  1  MDR source select: 1 = Mdatain, 0 = bus
IncPC  input  1  PC <= PC+1
ALU_opcode  input  5  ALU operation
Mdatain  input  32  memory read data
R0..R15, HI, LO, Y, ZLO, ZHI, IR  output  32 each  register contents
Z_register  output  64  Z contents

Behaviour:
- Reset: clr=1 asynchronously clears every register (R0-R15, HI, LO, PC, IR, MAR, MDR, Y, Z, ZHI, ZLO) to 0. R0 is an ordinary register and is not hardwired to zero.
- Bus select priority, highest first: R0out..R15out, HIout, Loout, ZHIout, ZLOout, Yout, PCout, MDRout, InPortout, Cout, ZHighSelect, ZLowSelect.
- With no strobe active, the bus is 32'h0.
- Cout drives C = IR[18:0] sign-extended to 32 bits.
- All register loads occur on the rising edge of clk; outputs reflect the register state.
- MDR loads Mdatain when MDRread=1, otherwise the bus, when MDRin=1.
- PC: PCin loads the bus and takes priority over IncPC; IncPC alone sets PC <= PC+1 with wrap-around.
- ALU is combinational: A = Y, B = bus; the result is 64-bit, with upper 32 bits 0 unless stated otherwise.
- Zin loads Z <= result. ZLOin loads ZLO <= result[31:0]. ZHIin loads ZHI <= result[63:32]. These may be asserted in the same cycle.
- Opcodes:
  - 00011 ADD A+B; 00100 SUB A-B (modulo 2^32)
  - 00101 AND; 00110 OR
  - 00111 ROR; 01000 ROL; 01001 SHR (logical); 01010 SHRA (arithmetic); 01011 SHL. All shifts/rotates of A by B[4:0].
  - 01111 MUL: signed 64-bit A*B.
  - 10000 DIV: signed; result[31:0] = quotient, [63:32] = remainder. B=0 gives result 0.
  - 10001 NEG: -B. 10010 NOT: ~B.
  - Any other opcode gives result 0.
- Simultaneous Yin and Yout: Y latches the bus value (its old value) and is unchanged.

Optional Feature:
- DP_INPORT_EN defined: adds input port InPort_data (32 bits); InPortout drives it onto the bus.
- Without DP_INPORT_EN: InPortout drives 32'h0.

Decomposition:
- Package dp_pkg: ALU opcode localparams (OP_ADD...OP_NOT) and the WIDTH constant.
- Sub-module dp_alu: combinational, A/B/opcode in, 64-bit result out.
- Bus encoder and registers stay in cpu_datapath.

Test Plan:
- Reset: assert clr mid-run with registers loaded -> all outputs 0 immediately, without waiting for a clock edge.
- Load path: Mdatain=32'h0000000F with MDRread+MDRin for one edge, then MDRout+R0in -> R0=32'h0000000F. Repeat with 32'h4 into R1 -> R1=32'h00000004.
- NOT: R1out+Yin (Y=4); then Yout, ALU_opcode=10010, Zin, ZLOin, ZLowSelect all together -> ZLO=32'hFFFFFFFB, Z_register=64'h00000000FFFFFFFB. Then ZLOout+R0in with ZLowSelect still high -> R0=32'hFFFFFFFB.
- ADD/SUB: Y=7, bus=5 -> ADD ZLO=12; SUB ZLO=2. SUB with Y=0, bus=1 -> 32'hFFFFFFFF.
- MUL/DIV: Y=-6, bus=4 -> MUL Z=64'hFFFFFFFFFFFFFFE8. Y=17, bus=5 -> DIV ZLO=3, ZHI=2. DIV with bus=0 -> Z=0.
- PC/priority: IncPC from 0 for 3 edges -> PC=3. With R2out and Yout both high -> bus = R2.
